codec_cfg_sequencer: RTL
========================

# codec_cfg_sequencer

Sequences every register write to the audio codec. It replaces the free-running counter-driven configuration with an explicit state machine that plays out a fixed power-up list, then shares the I2C write engine between two runtime requesters (volume control and path control) using round-robin arbitration. It sits between `i2c_protocol` and the user-side control logic. It also produces `codec_ready`, which enables the LR-clock generators.

## Interface

Parameters:
- `INIT_LEN`, 11: number of words in the power-up list.
- `MAX_RETRY`, 3: retries per word after a NACK or timeout before the word is abandoned.
- `GAP_CYCLES`, 1000: idle `clk` cycles enforced after every transaction completes.
- `TIMEOUT`, 4096: `clk` cycles allowed from `i2c_start` to `i2c_done`.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: volume requester has a word pending.
- `req0_word` in 16: `[15:9]` register address, `[8:0]` register data.
- `req0_ready` out 1: one-cycle grant pulse; the word is captured in that cycle.
- `req1_valid` in 1: path-control requester has a word pending.
- `req1_word` in 16: same format as `req0_word`.
- `req1_ready` out 1: one-cycle grant pulse for requester 1.
- `i2c_start` out 1: one-cycle pulse that launches a write.
- `i2c_word` out 16: word to write; held stable from `i2c_start` until `i2c_done`.
- `i2c_done` in 1: one-cycle pulse, `clk`-synchronous, marking the end of a transaction.
- `i2c_ack_ok` in 1: sampled with `i2c_done`; 1 means all three ACKs were received.
- `codec_ready` out 1: init list complete; enables the LR-clock generators.
- `cfg_error` out 1: sticky; set when any word is abandoned.
- `busy` out 1: a transaction or gap is in progress.

## Operation

Init list, by index 0..10:
- 0x1E00: reset
- 0x0017, 0x0217: line in L/R
- 0x0479, 0x0679: headphone L/R
- 0x0812, 0x0A00, 0x0C02, 0x0E23, 0x1001
- 0x1201: activate, always last

States:
- `INIT_ISSUE`: drive `i2c_word` from the init list at `idx`; pulse `i2c_start`; go to `WAIT`.
- `WAIT`: count the timeout.
  - On `i2c_done`: go to `GAP`, recording pass if `i2c_ack_ok`=1, else fail.
  - If the timeout count reaches `TIMEOUT` first: record fail and go to `GAP`.
- `GAP`: count `GAP_CYCLES`, then resolve the recorded result.
  - Pass: `retry` := 0; advance.
  - Fail with `retry` < `MAX_RETRY`: `retry`++, reissue the same word.
  - Fail with `retry` = `MAX_RETRY`: set `cfg_error`, `retry` := 0, advance.
  - Advance during init: `idx`++, or go to `RUN_IDLE` with `codec_ready`:=1 once `idx` = `INIT_LEN`-1.
  - Advance at runtime: return to `RUN_IDLE`.
  - Reissue goes to `INIT_ISSUE` during init, `RUN_ISSUE` at runtime.
- `RUN_IDLE`: if any `reqN_valid`, pulse the granted `reqN_ready`, capture its word, go to `RUN_ISSUE`.
- `RUN_ISSUE`: pulse `i2c_start` with the captured word; go to `WAIT`.

Arbitration:
- A `last` pointer resets to 1, so req0 wins the first tie.
- Both valid: grant the requester other than `last`. One valid: grant it.
- `last` updates on every grant.
- Requesters hold `valid` and `word` until `ready`.
- No grants while `codec_ready`=0.

Other rules:
- `i2c_done` outside `WAIT` is ignored.
- `busy` = state not in {`RUN_IDLE`}; it is also 1 throughout init.

## Timing

- Reset values: all outputs 0, `idx`=0, `retry`=0, `last`=1, state `INIT_ISSUE`.
- Reset assertion clears all state asynchronously, so an in-flight `i2c_start` drops the same instant.
- After reset release, `i2c_start` first pulses on the first `clk` edge, which moves `INIT_ISSUE` to `WAIT`. `i2c_start` is registered.
- Grant to I2C start: `reqN_ready` in cycle T, `i2c_start` in cycle T+1, `i2c_word` valid from T+1.
- `i2c_done` in cycle D: `GAP` covers D+1..D+`GAP_CYCLES`; the next issue happens at D+`GAP_CYCLES`+1.
- `codec_ready` rises at the end of the last init word's gap, at D+`GAP_CYCLES`+1, and stays 1 until reset.
- Timeout: fail is recorded when `TIMEOUT` cycles elapse after `i2c_start` with no `i2c_done`. A late `i2c_done` arriving during `GAP` is ignored.
- A valid input that drops before its grant is simply not granted; there is no error.

## Test plan

- **Clean init:** engine returns `i2c_done` with `ack_ok`=1 ten cycles after each start.
  - Required: exactly 11 starts with words 0x1E00…0x1201 in order.
  - Required: `codec_ready` rises `GAP_CYCLES`+1 cycles after the 11th done; `cfg_error`=0.
- **NACK retry:** word index 3 NACKs twice, then ACKs.
  - Required: 0x0479 is issued 3 times, `cfg_error`=0, and 13 starts in total.
- **Abandon:** index 5 always NACKs.
  - Required: 0x0812 is issued 4 times, `cfg_error` goes to 1, the sequence continues to 0x1201, and `codec_ready`=1.
- **Timeout:** `i2c_done` is never returned for index 0.
  - Required: 4 starts of 0x1E00 spaced `TIMEOUT`+`GAP_CYCLES`+1 apart, then `cfg_error`=1 and index 1 is issued.
- **Arbitration:** after init, both requesters valid continuously (req0 = 0x0460, req1 = 0x0A08).
  - Required: grants alternate req0, req1, req0, and `i2c_word` matches each grant.
  - Required: requests raised during init receive no grant until `codec_ready`.
- **Reset mid-transaction:** drop `reset` while in `WAIT` at index 7.
  - Required: `i2c_start`, `codec_ready` and `cfg_error` read 0 immediately.
  - Required: after release, the first issued word is 0x1E00.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// Codec register-write sequencer: plays the power-up list through the I2C write
// engine, then round-robin arbitrates two runtime requesters onto the same engine.
module codec_cfg_sequencer #(
   parameter int INIT_LEN   = 11,
   parameter int MAX_RETRY  = 3,
   parameter int GAP_CYCLES = 1000,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_word,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_word,
   output logic        req1_ready,
   output logic        i2c_start,
   output logic [15:0] i2c_word,
   input  logic        i2c_done,
   input  logic        i2c_ack_ok,
   output logic        codec_ready,
   output logic        cfg_error,
   output logic        busy
);

   localparam int IW      = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
   localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_INIT_ISSUE,
      S_WAIT,
      S_GAP,
      S_RUN_IDLE,
      S_RUN_ISSUE
   } state_t;

   function automatic logic [15:0] init_word(input logic [IW-1:0] i);
      case (int'(i))
         0:       init_word = 16'h1E00;
         1:       init_word = 16'h0017;
         2:       init_word = 16'h0217;
         3:       init_word = 16'h0479;
         4:       init_word = 16'h0679;
         5:       init_word = 16'h0812;
         6:       init_word = 16'h0A00;
         7:       init_word = 16'h0C02;
         8:       init_word = 16'h0E23;
         9:       init_word = 16'h1001;
         default: init_word = 16'h1201;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pass_q, pass_d;
   logic            last_q, last_d;
   logic            i2c_start_q, i2c_start_d;
   logic [15:0]     i2c_word_q, i2c_word_d;
   logic            req0_ready_q, req0_ready_d;
   logic            req1_ready_q, req1_ready_d;
   logic            codec_ready_q, codec_ready_d;
   logic            cfg_error_q, cfg_error_d;
   logic            busy_q, busy_d;
   logic            grant1;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d       = state_q;
      idx_d         = idx_q;
      retry_d       = retry_q;
      cnt_d         = cnt_q;
      pass_d        = pass_q;
      last_d        = last_q;
      i2c_start_d   = 1'b0;
      i2c_word_d    = i2c_word_q;
      req0_ready_d  = 1'b0;
      req1_ready_d  = 1'b0;
      codec_ready_d = codec_ready_q;
      cfg_error_d   = cfg_error_q;
      grant1        = req1_valid && (!req0_valid || !last_q);

      case (state_q)
         S_INIT_ISSUE: begin
            i2c_start_d = 1'b1;
            i2c_word_d  = init_word(idx_q);
            cnt_d       = '0;
            state_d     = S_WAIT;
         end
         S_RUN_ISSUE: begin
            i2c_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (i2c_done) begin
               pass_d  = i2c_ack_ok;
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               pass_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               if (pass_q || retry_q == RW'(MAX_RETRY)) begin
                  // Either the word landed or it is abandoned; both move on.
                  if (!pass_q) cfg_error_d = 1'b1;
                  retry_d = '0;
                  if (codec_ready_q) begin
                     state_d = S_RUN_IDLE;
                  end else if (idx_q == IW'(INIT_LEN - 1)) begin
                     codec_ready_d = 1'b1;
                     state_d       = S_RUN_IDLE;
                  end else begin
                     idx_d   = idx_q + IW'(1);
                     state_d = S_INIT_ISSUE;
                  end
               end else begin
                  retry_d = retry_q + RW'(1);
                  state_d = codec_ready_q ? S_RUN_ISSUE : S_INIT_ISSUE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN_IDLE: begin
            if (req0_valid || req1_valid) begin
               req1_ready_d = grant1;
               req0_ready_d = !grant1;
               i2c_word_d   = grant1 ? req1_word : req0_word;
               last_d       = grant1;
               state_d      = S_RUN_ISSUE;
            end
         end
         default: state_d = S_INIT_ISSUE;
      endcase

      busy_d = (state_d != S_RUN_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_INIT_ISSUE;
         idx_q         <= '0;
         retry_q       <= '0;
         cnt_q         <= '0;
         pass_q        <= 1'b0;
         last_q        <= 1'b1;
         i2c_start_q   <= 1'b0;
         i2c_word_q    <= '0;
         req0_ready_q  <= 1'b0;
         req1_ready_q  <= 1'b0;
         codec_ready_q <= 1'b0;
         cfg_error_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q       <= state_d;
         idx_q         <= idx_d;
         retry_q       <= retry_d;
         cnt_q         <= cnt_d;
         pass_q        <= pass_d;
         last_q        <= last_d;
         i2c_start_q   <= i2c_start_d;
         i2c_word_q    <= i2c_word_d;
         req0_ready_q  <= req0_ready_d;
         req1_ready_q  <= req1_ready_d;
         codec_ready_q <= codec_ready_d;
         cfg_error_q   <= cfg_error_d;
         busy_q        <= busy_d;
      end
   end

   assign i2c_start   = i2c_start_q;
   assign i2c_word    = i2c_word_q;
   assign req0_ready  = req0_ready_q;
   assign req1_ready  = req1_ready_q;
   assign codec_ready = codec_ready_q;
   assign cfg_error   = cfg_error_q;
   assign busy        = busy_q;

endmodule
